// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns a valid/ready request channel into single SETUP->ACCESS transfers
// with one response strobe each. Define APB_MASTER_TIMEOUT_EN to enable the ACCESS timeout.
module apb_master_bridge #(
  parameter int unsigned PADDR_SIZE = 16,
  parameter int unsigned PDATA_SIZE = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  PRESETn,
  input  logic                  PCLK,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PADDR_SIZE-1:0] req_addr,
  input  logic                  req_write,
  input  logic [PDATA_SIZE-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [PDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_tmo,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [PADDR_SIZE-1:0] PADDR,
  output logic                  PWRITE,
  output logic [PDATA_SIZE-1:0] PWDATA,
  input  logic [PDATA_SIZE-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [PDATA_SIZE-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  abort;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            tmo_q, tmo_d;

  assign cnt_inc = cnt_q + CntW'(1);
  // Abort on the ACCESS cycle whose wait would bring the count to TIMEOUT; PREADY=1 wins.
  assign abort   = (state_q == StAccess) && !PREADY && (cnt_inc == CntW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !PREADY) begin
      cnt_d = cnt_inc;
    end
    if (rsp_valid_d) begin
      tmo_d = abort;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign rsp_tmo = tmo_q;
`else
  assign abort   = 1'b0;
  assign rsp_tmo = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d  = StSetup;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          err_d       = PSLVERR;
          rdata_d     = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
        end else if (abort) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // APB strobes are registered copies of the next state.
    psel_d    = (state_d != StIdle);
    penable_d = (state_d == StAccess);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
